alsu_ctrl: RTL
==============

ALSU_CTRL -- requirements
Module: alsu_ctrl

Interface
REQ-001 Parameter DATAWIDTH, default 16, SHALL set the operand, register and result width.
REQ-002 Parameter FUNCBITS, default 3, SHALL set the ALU function-code width.
REQ-003 Parameter NREGS, default 8, SHALL set the register-file depth, with addresses 3 bits wide.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  SHALL be the reset, asynchronous and active-high.
REQ-006 instr_valid  in  1  SHALL indicate that an instruction is offered.
REQ-007 instr_ready  out  1  SHALL indicate that the controller accepts an instruction this cycle.
REQ-008 instr  in  16  SHALL carry the instruction: [15:13] func, [12:10] rd, [9:7] ra, [6:4] rb, [3] setf, [2:0] ignored.
REQ-009 wr_en, wr_addr, wr_data  in  1/3/DATAWIDTH  SHALL form the external register-load port.
REQ-010 alu_a, alu_b, alu_func  out  DATAWIDTH/DATAWIDTH/FUNCBITS  SHALL drive the ALU operands and function.
REQ-011 alu_r, alu_z, alu_n, alu_c  in  DATAWIDTH/1/1/1  SHALL receive the ALU result and flags.
REQ-012 done  out  1  SHALL be a one-cycle pulse marking writeback.
REQ-013 res_out  out  DATAWIDTH  SHALL hold the last captured result.
REQ-014 flag_z, flag_n, flag_c  out  1  SHALL present the registered condition flags.

Function
REQ-015 The FSM SHALL have three states: IDLE, EXEC and WB.
REQ-016 FSM transitions: IDLE->EXEC on instr_valid&&instr_ready; EXEC->WB unconditionally; WB->IDLE unconditionally.
REQ-017 instr_ready SHALL be 1 only in IDLE; instr_valid outside IDLE SHALL be ignored, and the source holds instr until accepted.
REQ-018 On acceptance, func, rd and setf SHALL be latched, and regs[ra] and regs[rb] SHALL be read into operand registers.
REQ-019 In EXEC, alu_a, alu_b and alu_func SHALL come from the latched registers; at the end of EXEC, alu_r, alu_z, alu_n and alu_c SHALL be captured.
REQ-020 In WB, the captured result SHALL be written to regs[rd] and to res_out, and done SHALL be 1.
REQ-021 In WB, flags SHALL update from the captured ALU flags only if setf=1; otherwise they SHALL hold.
REQ-022 Latency: for an instruction accepted at edge T, done SHALL be high in the cycle after edge T+2; throughput SHALL be one instruction per 3 cycles.
REQ-023 Register 0 SHALL read as zero, and writes to register 0 (WB or external) SHALL be discarded.
REQ-024 When WB and an external write target the same address in the same cycle, WB SHALL win; writes to different addresses SHALL both complete.
REQ-025 External writes SHALL be accepted in every state.
REQ-026 Outside EXEC, alu_a, alu_b and alu_func SHALL hold their last values.
REQ-027 All arithmetic SHALL occur in the ALU; the controller SHALL perform no width extension or truncation.

Reset
REQ-028 While rst=1, the FSM SHALL be in IDLE, all registers and operand latches SHALL be 0, and res_out, alu_a, alu_b, alu_func, flag_z, flag_n, flag_c and done SHALL be 0.
REQ-029 After rst deasserts, instr_ready SHALL be 1.
REQ-030 Reset asserted in EXEC or WB SHALL abort the instruction with no register write and no done pulse.

Configuration
REQ-031 Macro ALSU_CTRL_BYPASS_EN, when defined, SHALL make an operand read in the acceptance cycle return wr_data if wr_en=1 and wr_addr matches ra/rb (nonzero).
REQ-032 Without ALSU_CTRL_BYPASS_EN, the operand read SHALL return the pre-edge register value.

Structure
REQ-033 Package alsu_pkg SHALL hold the FUNC encodings (ADD 000, SUB 001, SHL 010, SHR 011, AND 100, XOR 101, NOT 110, INC 111), the instr field positions and the FSM state encoding.
REQ-034 The register file SHALL be sub-module alsu_regfile: 2 async read ports, 2 write ports with priority, and r0 hardwired to zero.

Verification
REQ-035 Load r1=0x7FFF and r2=0x0001, then issue ADD rd=3 ra=1 rb=2 setf=1 -> done 2 cycles after the accept edge, r3=0x8000, N=1, Z=0, C=0.
REQ-036 Load r4=0x1234, then issue SUB rd=5 ra=4 rb=4 setf=1 -> r5=0x0000, Z=1, C=1, N=0.
REQ-037 With flags Z=1, issue XOR rd=6 ra=1 rb=2 setf=0 -> r6=0x7FFE and flags unchanged.
REQ-038 Issue INC rd=0 ra=1, and separately do an external write r0=0xFFFF -> r0 still reads 0.
REQ-039 Assert rst during EXEC of ADD rd=3 -> no done, r3=0, instr_ready=1 after release.
REQ-040 In the acceptance cycle of ADD rd=7 ra=1 rb=2, perform an external write r1=0x0005 -> r7=0x0006 with ALSU_CTRL_BYPASS_EN and r7=0x8000 without it.

Source files
------------

// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU controller: function codes, instruction
// field positions and FSM state encoding.
package alsu_pkg;

    localparam int INSTR_W  = 16;
    localparam int ADDR_W   = 3;

    // Instruction field LSB positions.
    localparam int FUNC_LSB = 13;
    localparam int RD_LSB   = 10;
    localparam int RA_LSB   = 7;
    localparam int RB_LSB   = 4;
    localparam int SETF_BIT = 3;

    typedef enum logic [2:0] {
        FUNC_ADD = 3'b000,
        FUNC_SUB = 3'b001,
        FUNC_SHL = 3'b010,
        FUNC_SHR = 3'b011,
        FUNC_AND = 3'b100,
        FUNC_XOR = 3'b101,
        FUNC_NOT = 3'b110,
        FUNC_INC = 3'b111
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alsu_ctrl_if.sv
// Instruction handshake between an instruction source (master) and the
// ALSU controller (slave).
interface alsu_ctrl_if;
    import alsu_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/alsu_regfile.sv
// Register file: two asynchronous read ports, two write ports where the
// priority port wins on an address collision, r0 hardwired to zero.
module alsu_regfile
    import alsu_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int NREGS     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    ra_addr,
    input  logic [ADDR_W-1:0]    rb_addr,
    output logic [DATAWIDTH-1:0] ra_data,
    output logic [DATAWIDTH-1:0] rb_data,
    input  logic                 we_pri,
    input  logic [ADDR_W-1:0]    wa_pri,
    input  logic [DATAWIDTH-1:0] wd_pri,
    input  logic                 we_sec,
    input  logic [ADDR_W-1:0]    wa_sec,
    input  logic [DATAWIDTH-1:0] wd_sec
);

    logic [DATAWIDTH-1:0] mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else begin
            // Entry 0 is never written, so it stays at its reset value.
            for (int i = 1; i < NREGS; i++) begin
                if (we_pri && wa_pri == ADDR_W'(i))
                    mem[i] <= wd_pri;
                else if (we_sec && wa_sec == ADDR_W'(i))
                    mem[i] <= wd_sec;
            end
        end
    end

    assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];

endmodule

// File: rtl/alsu_ctrl.sv
// ALSU controller: IDLE -> EXEC -> WB sequencer around an external ALU.
// Optional macro ALSU_CTRL_BYPASS_EN forwards a same-cycle external write into operand fetch.
module alsu_ctrl
    import alsu_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int FUNCBITS  = 3,
    parameter int NREGS     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alsu_ctrl_if.slave           bus,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATAWIDTH-1:0] wr_data,
    output logic [DATAWIDTH-1:0] alu_a,
    output logic [DATAWIDTH-1:0] alu_b,
    output logic [FUNCBITS-1:0]  alu_func,
    input  logic [DATAWIDTH-1:0] alu_r,
    input  logic                 alu_z,
    input  logic                 alu_n,
    input  logic                 alu_c,
    output logic                 done,
    output logic [DATAWIDTH-1:0] res_out,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 flag_c
);

    state_e state, state_nxt;
    logic   ready, accept, wb_en;

    logic [ADDR_W-1:0]    ra, rb;
    logic [DATAWIDTH-1:0] ra_data, rb_data, opa_in, opb_in;

    // Acceptance-stage latches
    logic [DATAWIDTH-1:0] opa_p0, opb_p0;
    logic [FUNCBITS-1:0]  func_p0;
    logic [ADDR_W-1:0]    rd_p0;
    logic                 setf_p0;

    // EXEC-capture registers
    logic [DATAWIDTH-1:0] res_p1;
    logic                 z_p1, n_p1, c_p1;

    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instr[2:0];

    assign ra = bus.instr[RA_LSB +: ADDR_W];
    assign rb = bus.instr[RB_LSB +: ADDR_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        wb_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.instr_valid) state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_WB;
            ST_WB: begin
                wb_en     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.instr_ready = ready;
    assign accept          = bus.instr_valid && ready;

    alsu_regfile #(
        .DATAWIDTH (DATAWIDTH),
        .NREGS     (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (ra),
        .rb_addr (rb),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .we_pri  (wb_en),
        .wa_pri  (rd_p0),
        .wd_pri  (res_p1),
        .we_sec  (wr_en),
        .wa_sec  (wr_addr),
        .wd_sec  (wr_data)
    );

`ifdef ALSU_CTRL_BYPASS_EN
    assign opa_in = (wr_en && ra != '0 && wr_addr == ra) ? wr_data : ra_data;
    assign opb_in = (wr_en && rb != '0 && wr_addr == rb) ? wr_data : rb_data;
`else
    assign opa_in = ra_data;
    assign opb_in = rb_data;
`endif

    // Stage p0: operand fetch and decode on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_p0  <= '0;
            opb_p0  <= '0;
            func_p0 <= '0;
            rd_p0   <= '0;
            setf_p0 <= 1'b0;
        end else if (accept) begin
            opa_p0  <= opa_in;
            opb_p0  <= opb_in;
            func_p0 <= bus.instr[FUNC_LSB +: FUNCBITS];
            rd_p0   <= bus.instr[RD_LSB +: ADDR_W];
            setf_p0 <= bus.instr[SETF_BIT];
        end
    end

    // The operand latches only change on entry to EXEC, so they double as
    // the held ALU drive outside EXEC.
    assign alu_a    = opa_p0;
    assign alu_b    = opb_p0;
    assign alu_func = func_p0;

    // Stage p1: capture ALU outputs at the end of EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_p1 <= '0;
            z_p1   <= 1'b0;
            n_p1   <= 1'b0;
            c_p1   <= 1'b0;
        end else if (state == ST_EXEC) begin
            res_p1 <= alu_r;
            z_p1   <= alu_z;
            n_p1   <= alu_n;
            c_p1   <= alu_c;
        end
    end

    // Stage p2: writeback of result, flags and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done    <= 1'b0;
            res_out <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_c  <= 1'b0;
        end else begin
            done <= wb_en;
            if (wb_en) begin
                res_out <= res_p1;
                if (setf_p0) begin
                    flag_z <= z_p1;
                    flag_n <= n_p1;
                    flag_c <= c_p1;
                end
            end
        end
    end

endmodule
